// File: rtl/id_uop_if.sv
// id_uop_if: IF-side push and EX-side pop channels of the ID micro-op queue.
//   slave  : view taken by id_uop_queue (accepts instructions, presents uops)
//   master : view taken by the producer/consumer side (fetch and execute)
//   in_*   : valid/ready push of {pc, inst, inslot}
//   out_*  : valid/ready pop of the decoded head uop
interface id_uop_if #(
    parameter int unsigned AOP_W  = 12,
    parameter int unsigned MMOP_W = 8
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [31:0]       in_pc_i;
    logic [31:0]       in_inst_i;
    logic              in_inslot_i;

    logic              out_valid_o;
    logic              out_ready_i;
    logic [31:0]       out_pc_o;
    logic [31:0]       out_inst_o;
    logic              out_inslot_o;
    logic [AOP_W-1:0]  out_aluop_o;
    logic [MMOP_W-1:0] out_memop_o;
    logic              out_ren1_o;
    logic              out_ren2_o;
    logic [4:0]        out_raddr1_o;
    logic [4:0]        out_raddr2_o;
    logic              out_wren_o;
    logic [4:0]        out_waddr_o;
    logic [31:0]       out_imm_o;
    logic [2:0]        out_src_sel_o;
    logic [3:0]        out_br_type_o;
    logic [31:0]       out_br_target_o;
    logic              out_ri_o;

    modport slave (
        input  in_valid_i, in_pc_i, in_inst_i, in_inslot_i, out_ready_i,
        output in_ready_o, out_valid_o, out_pc_o, out_inst_o, out_inslot_o,
               out_aluop_o, out_memop_o, out_ren1_o, out_ren2_o, out_raddr1_o,
               out_raddr2_o, out_wren_o, out_waddr_o, out_imm_o, out_src_sel_o,
               out_br_type_o, out_br_target_o, out_ri_o
    );

    modport master (
        output in_valid_i, in_pc_i, in_inst_i, in_inslot_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_pc_o, out_inst_o, out_inslot_o,
               out_aluop_o, out_memop_o, out_ren1_o, out_ren2_o, out_raddr1_o,
               out_raddr2_o, out_wren_o, out_waddr_o, out_imm_o, out_src_sel_o,
               out_br_type_o, out_br_target_o, out_ri_o
    );
endinterface

// File: rtl/id_uop_queue.sv
// id_uop_queue: MIPS32 decode stage. Each accepted instruction is decoded into a uop and
// buffered in a DEPTH-entry FIFO between IF and EX. The head uop is held back while EX has a
// load whose destination it reads.
//   clk, rst_n         : clock, synchronous active-low reset
//   flush_i            : drop all queued uops and any same-cycle push/pop
//   bus (slave)        : in_* push channel from IF, out_* uop channel to EX
//   ex_load_valid_i    : EX holds a load
//   ex_load_waddr_i    : destination register of that load
//   count_o            : queue occupancy
//   stall_cnt_o        : saturating count of cycles the head was held by a load-use hazard
// ALU one-hot bits: 0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 or, 6 xor, 7 nor, 8 sll, 9 srl,
// 10 sra, 11 lui. Mem one-hot bits: 0 lb, 1 lbu, 2 lh, 3 lhu, 4 lw, 5 sb, 6 sh, 7 sw.
module id_uop_queue #(
    parameter int unsigned DEPTH         = 4,
    parameter int unsigned AOP_W         = 12,
    parameter int unsigned MMOP_W        = 8,
    parameter bit          LOAD_USE_HOLD = 1'b1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    id_uop_if.slave                  bus,
    input  logic                     ex_load_valid_i,
    input  logic [4:0]               ex_load_waddr_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [CNT_W-1:0]         stall_cnt_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       inst;
        logic              inslot;
        logic [AOP_W-1:0]  aluop;
        logic [MMOP_W-1:0] memop;
        logic              ren1;
        logic              ren2;
        logic [4:0]        raddr1;
        logic [4:0]        raddr2;
        logic              wren;
        logic [4:0]        waddr;
        logic [31:0]       imm;
        logic [2:0]        src_sel;
        logic [3:0]        br_type;
        logic [31:0]       br_target;
        logic              ri;
    } uop_t;

    uop_t            mem_q [DEPTH];
    uop_t            last_q, last_d;
    uop_t            dec, head, disp;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic            empty, hold, in_ready, out_valid, push, pop;

    // ---------------------------------------------------------------- decode
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm16;
    logic [31:0] sext, pc4, btgt, jtgt;
    logic [11:0] aop;
    logic [7:0]  mop;
    logic        ren1, ren2, wren, link, itype, ri, rr;
    logic [31:0] imm, tgt;
    logic [2:0]  src;
    logic [3:0]  br;

    assign op    = bus.in_inst_i[31:26];
    assign rs    = bus.in_inst_i[25:21];
    assign rt    = bus.in_inst_i[20:16];
    assign rd    = bus.in_inst_i[15:11];
    assign sa    = bus.in_inst_i[10:6];
    assign funct = bus.in_inst_i[5:0];
    assign imm16 = bus.in_inst_i[15:0];
    assign sext  = {{16{imm16[15]}}, imm16};
    assign pc4   = bus.in_pc_i + 32'd4;
    assign btgt  = pc4 + {sext[29:0], 2'b00};
    assign jtgt  = {pc4[31:28], bus.in_inst_i[25:0], 2'b00};

    always_comb begin
        aop = '0; mop = '0; ren1 = 1'b0; ren2 = 1'b0; wren = 1'b0; link = 1'b0;
        itype = 1'b0; ri = 1'b0; rr = 1'b0; imm = '0; src = '0; br = '0; tgt = '0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h03: begin  // shift by sa: src1 is sa, src2 is rt
                        ren2 = 1'b1; wren = 1'b1; imm = {27'b0, sa}; src = 3'b001;
                        aop[8] = (funct == 6'h00); aop[9] = (funct == 6'h02);
                        aop[10] = (funct == 6'h03);
                    end
                    6'h04, 6'h06, 6'h07: begin
                        rr = 1'b1;
                        aop[8] = (funct == 6'h04); aop[9] = (funct == 6'h06);
                        aop[10] = (funct == 6'h07);
                    end
                    6'h08: begin ren1 = 1'b1; br = 4'd11; end
                    6'h09: begin ren1 = 1'b1; link = 1'b1; br = 4'd12; end
                    6'h20, 6'h21: begin rr = 1'b1; aop[0] = 1'b1; end
                    6'h22, 6'h23: begin rr = 1'b1; aop[1] = 1'b1; end
                    6'h24: begin rr = 1'b1; aop[4] = 1'b1; end
                    6'h25: begin rr = 1'b1; aop[5] = 1'b1; end
                    6'h26: begin rr = 1'b1; aop[6] = 1'b1; end
                    6'h27: begin rr = 1'b1; aop[7] = 1'b1; end
                    6'h2a: begin rr = 1'b1; aop[2] = 1'b1; end
                    6'h2b: begin rr = 1'b1; aop[3] = 1'b1; end
                    default: ri = 1'b1;
                endcase
            end
            6'h01: begin
                ren1 = 1'b1; imm = sext; tgt = btgt;
                case (rt)
                    5'h00: br = 4'd6;
                    5'h01: br = 4'd3;
                    5'h10: begin br = 4'd8; link = 1'b1; end
                    5'h11: begin br = 4'd7; link = 1'b1; end
                    default: ri = 1'b1;
                endcase
            end
            6'h02: begin br = 4'd9; tgt = jtgt; end
            6'h03: begin br = 4'd10; tgt = jtgt; link = 1'b1; end
            6'h04, 6'h05: begin
                ren1 = 1'b1; ren2 = 1'b1; imm = sext; tgt = btgt;
                br = (op == 6'h04) ? 4'd1 : 4'd2;
            end
            6'h06, 6'h07: begin
                ren1 = 1'b1; imm = sext; tgt = btgt;
                br = (op == 6'h06) ? 4'd5 : 4'd4;
            end
            6'h08, 6'h09, 6'h0a, 6'h0b: begin
                ren1 = 1'b1; wren = 1'b1; itype = 1'b1; imm = sext; src = 3'b100;
                aop[0] = (op == 6'h08) || (op == 6'h09);
                aop[2] = (op == 6'h0a); aop[3] = (op == 6'h0b);
            end
            6'h0c, 6'h0d, 6'h0e: begin
                ren1 = 1'b1; wren = 1'b1; itype = 1'b1; imm = {16'b0, imm16}; src = 3'b100;
                aop[4] = (op == 6'h0c); aop[5] = (op == 6'h0d); aop[6] = (op == 6'h0e);
            end
            6'h0f: begin
                wren = 1'b1; itype = 1'b1; imm = {imm16, 16'b0}; src = 3'b100; aop[11] = 1'b1;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                ren1 = 1'b1; wren = 1'b1; itype = 1'b1; imm = sext; src = 3'b100;
                aop[0] = 1'b1;
                mop[0] = (op == 6'h20); mop[1] = (op == 6'h24); mop[2] = (op == 6'h21);
                mop[3] = (op == 6'h25); mop[4] = (op == 6'h23);
            end
            6'h28, 6'h29, 6'h2b: begin
                ren1 = 1'b1; ren2 = 1'b1; itype = 1'b1; imm = sext; src = 3'b100;
                aop[0] = 1'b1;
                mop[5] = (op == 6'h28); mop[6] = (op == 6'h29); mop[7] = (op == 6'h2b);
            end
            default: ri = 1'b1;
        endcase
        if (rr) begin
            ren1 = 1'b1; ren2 = 1'b1; wren = 1'b1;
        end
        // Linking branches/jumps compute pc+8 in the ALU.
        if (link) begin
            wren = 1'b1; aop = 12'h001; src = 3'b011;
        end
    end

    always_comb begin
        dec           = '0;
        dec.pc        = bus.in_pc_i;
        dec.inst      = bus.in_inst_i;
        dec.inslot    = bus.in_inslot_i;
        dec.ri        = ri;
        if (!ri) begin
            dec.aluop     = AOP_W'(aop);
            dec.memop     = MMOP_W'(mop);
            dec.ren1      = ren1;
            dec.ren2      = ren2;
            dec.raddr1    = ren1 ? rs : 5'd0;
            dec.raddr2    = ren2 ? rt : 5'd0;
            dec.wren      = wren;
            dec.waddr     = link ? 5'd31 : (itype ? rt : rd);
            dec.imm       = imm;
            dec.src_sel   = src;
            dec.br_type   = br;
            dec.br_target = tgt;
        end
    end

    // ---------------------------------------------------------------- queue control
    assign head      = mem_q[rd_ptr_q];
    assign empty     = (count_q == '0);
    assign hold      = LOAD_USE_HOLD && ex_load_valid_i && (ex_load_waddr_i != 5'd0) &&
                       ((head.ren1 && (head.raddr1 == ex_load_waddr_i)) ||
                        (head.ren2 && (head.raddr2 == ex_load_waddr_i)));
    assign in_ready  = (count_q < CntW'(DEPTH));
    assign out_valid = !empty && !hold && !flush_i;
    assign push      = bus.in_valid_i && in_ready && !flush_i;
    assign pop       = out_valid && bus.out_ready_i;
    // With nothing queued, EX sees the last uop it popped (zero after reset or flush).
    assign disp      = empty ? last_q : head;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        last_d      = last_q;
        stall_cnt_d = stall_cnt_q;
        if (!empty && hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            last_d   = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PtrW'(push);
            rd_ptr_d = rd_ptr_q + PtrW'(pop);
            count_d  = count_q + CntW'(push) - CntW'(pop);
            if (pop) begin
                last_d = head;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            last_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            last_q      <= last_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Storage needs no reset: entries are only observed while counted as occupied.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dec;
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.in_ready_o      = in_ready;
    assign bus.out_valid_o     = out_valid;
    assign bus.out_pc_o        = disp.pc;
    assign bus.out_inst_o      = disp.inst;
    assign bus.out_inslot_o    = disp.inslot;
    assign bus.out_aluop_o     = disp.aluop;
    assign bus.out_memop_o     = disp.memop;
    assign bus.out_ren1_o      = disp.ren1;
    assign bus.out_ren2_o      = disp.ren2;
    assign bus.out_raddr1_o    = disp.raddr1;
    assign bus.out_raddr2_o    = disp.raddr2;
    assign bus.out_wren_o      = disp.wren;
    assign bus.out_waddr_o     = disp.waddr;
    assign bus.out_imm_o       = disp.imm;
    assign bus.out_src_sel_o   = disp.src_sel;
    assign bus.out_br_type_o   = disp.br_type;
    assign bus.out_br_target_o = disp.br_target;
    assign bus.out_ri_o        = disp.ri;
    assign count_o             = count_q;
    assign stall_cnt_o         = stall_cnt_q;
endmodule

// File: tb/tb_id_uop_queue.sv
// Scoreboard bench for id_uop_queue: stimulus pushes hand-computed expected uops, an
// independent monitor pops and compares whenever EX accepts a uop.
module tb_id_uop_queue;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        ex_lv = 1'b0;
    logic [4:0]  ex_lw = 5'd0;
    logic [2:0]  count, count1;
    logic [15:0] stall, stall1;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct packed {
        logic        full;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [110:0] f;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    id_uop_if #(.AOP_W(12), .MMOP_W(8)) bus ();
    id_uop_if #(.AOP_W(12), .MMOP_W(8)) bus1 ();

    id_uop_queue #(.DEPTH(4), .AOP_W(12), .MMOP_W(8), .LOAD_USE_HOLD(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .bus(bus),
        .ex_load_valid_i(ex_lv), .ex_load_waddr_i(ex_lw), .count_o(count), .stall_cnt_o(stall)
    );

    id_uop_queue #(.DEPTH(4), .AOP_W(12), .MMOP_W(8), .LOAD_USE_HOLD(1'b0), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush_i(1'b0), .bus(bus1),
        .ex_load_valid_i(ex_lv), .ex_load_waddr_i(ex_lw), .count_o(count1), .stall_cnt_o(stall1)
    );

    always #5 clk = ~clk;

    logic [110:0] act;
    assign act = {bus.out_inslot_o, bus.out_aluop_o, bus.out_memop_o, bus.out_ren1_o,
                  bus.out_ren2_o, bus.out_raddr1_o, bus.out_raddr2_o, bus.out_wren_o,
                  bus.out_waddr_o, bus.out_imm_o, bus.out_src_sel_o, bus.out_br_type_o,
                  bus.out_br_target_o, bus.out_ri_o};

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [110:0] uf(input logic inslot, input logic [11:0] aop,
            input logic [7:0] mop, input logic r1, input logic r2, input logic [4:0] a1,
            input logic [4:0] a2, input logic we, input logic [4:0] wa, input logic [31:0] imm,
            input logic [2:0] src, input logic [3:0] br, input logic [31:0] tgt, input logic ri);
        return {inslot, aop, mop, r1, r2, a1, a2, we, wa, imm, src, br, tgt, ri};
    endfunction

    function automatic exp_t fx(input logic [31:0] pc, input logic [31:0] inst,
                                input logic [110:0] f);
        return '{full: 1'b1, pc: pc, inst: inst, f: f};
    endfunction

    // Order-only entry: addiu r2,r1,k, tracked by pc and instruction word.
    function automatic exp_t ord(input logic [31:0] pc, input logic [15:0] k);
        return '{full: 1'b0, pc: pc, inst: {16'h2422, k}, f: '0};
    endfunction

    // Monitor: a uop is delivered on every negedge with out_valid & out_ready.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_pop: got pc %h expected no uop", bus.out_pc_o);
            end else begin
                mon_e = sb_q.pop_front();
                chk("pop_pc", 128'(bus.out_pc_o), 128'(mon_e.pc));
                chk("pop_inst", 128'(bus.out_inst_o), 128'(mon_e.inst));
                if (mon_e.full) chk("pop_uop", 128'(act), 128'(mon_e.f));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input exp_t e, input logic inslot);
        bus.in_valid_i  = 1'b1;
        bus.in_pc_i     = e.pc;
        bus.in_inst_i   = e.inst;
        bus.in_inslot_i = inslot;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (bus.in_ready_o) begin
                sb_q.push_back(e);
                @(posedge clk);
                #1;
                bus.in_valid_i = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        n_fail++;
        $display("FAIL push_timeout: got in_ready 0 expected 1 within 50 cycles");
        bus.in_valid_i = 1'b0;
    endtask

    task automatic chk_idle(input string name, input logic [15:0] want_stall);
        chk({name, "_count"}, 128'(count), 128'(0));
        chk({name, "_valid"}, 128'(bus.out_valid_o), 128'(0));
        chk({name, "_ready"}, 128'(bus.in_ready_o), 128'(1));
        chk({name, "_stall"}, 128'(stall), 128'(want_stall));
        chk({name, "_pcinst"}, 128'({bus.out_pc_o, bus.out_inst_o}), 128'(0));
        chk({name, "_fields"}, 128'(act), 128'(0));
    endtask

    initial begin
        bus.in_valid_i = 1'b0; bus.in_pc_i = '0; bus.in_inst_i = '0; bus.in_inslot_i = 1'b0;
        bus.out_ready_i = 1'b0;
        bus1.in_valid_i = 1'b0; bus1.in_pc_i = '0; bus1.in_inst_i = '0;
        bus1.in_inslot_i = 1'b0; bus1.out_ready_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk_idle("reset", 16'd0);
        @(posedge clk);
        #1;

        // First uop: addiu r2,r1,5, not visible in its push cycle
        bus.out_ready_i = 1'b1;
        bus.in_valid_i = 1'b1; bus.in_pc_i = 32'hBFC00000; bus.in_inst_i = 32'h24220005;
        @(negedge clk);
        chk("no_bypass", 128'(bus.out_valid_o), 128'(0));
        sb_q.push_back(fx(32'hBFC00000, 32'h24220005,
            uf(0, 12'h001, 8'h00, 1, 0, 5'd1, 5'd0, 1, 5'd2, 32'h5, 3'b100, 4'd0, 32'h0, 0)));
        @(posedge clk);
        #1 bus.in_valid_i = 1'b0;
        @(negedge clk);
        chk("first_valid", 128'(bus.out_valid_o), 128'(1));
        @(posedge clk);
        #1;

        // Decode vectors streamed through
        push(fx(32'hBFC00004, 32'h8C250008,
            uf(1, 12'h001, 8'h10, 1, 0, 5'd1, 5'd0, 1, 5'd5, 32'h8, 3'b100, 4'd0, 32'h0, 0)), 1'b1);
        push(fx(32'hBFC00008, 32'h000838C0,
            uf(0, 12'h100, 8'h00, 0, 1, 5'd0, 5'd8, 1, 5'd7, 32'h3, 3'b001, 4'd0, 32'h0, 0)), 1'b0);
        push(fx(32'hBFC0000C, 32'h34098001,
            uf(0, 12'h020, 8'h00, 1, 0, 5'd0, 5'd0, 1, 5'd9, 32'h8001, 3'b100, 4'd0, 32'h0, 0)),
            1'b0);
        push(fx(32'h80000100, 32'h04D1FFFF,
            uf(0, 12'h001, 8'h00, 1, 0, 5'd6, 5'd0, 1, 5'd31, 32'hFFFFFFFF, 3'b011, 4'd7,
               32'h80000100, 0)), 1'b0);
        push(fx(32'h9FC00000, 32'h0C100040,
            uf(0, 12'h001, 8'h00, 0, 0, 5'd0, 5'd0, 1, 5'd31, 32'h0, 3'b011, 4'd10,
               32'h90400100, 0)), 1'b0);
        push(fx(32'h00000040, 32'hFC000000,
            uf(0, 12'h000, 8'h00, 0, 0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 3'b000, 4'd0, 32'h0, 1)),
            1'b0);
        cyc(3);

        // Fill to DEPTH with EX stalled, then a refused push in the first draining cycle
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 4; k++) push(ord(32'h1000 + 32'(4 * k), 16'(k)), 1'b0);
        @(negedge clk);
        chk("full_count", 128'(count), 128'(4));
        chk("full_ready", 128'(bus.in_ready_o), 128'(0));
        @(posedge clk);
        #1;
        bus.out_ready_i = 1'b1;
        bus.in_valid_i = 1'b1; bus.in_pc_i = 32'h1010; bus.in_inst_i = 32'h24220004;
        @(negedge clk);
        chk("full_refuse", 128'(bus.in_ready_o), 128'(0));
        chk("refuse_count", 128'(count), 128'(4));
        @(posedge clk);
        #1 bus.in_valid_i = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            @(negedge clk);
            chk("drain_count", 128'(count), 128'(k));
            @(posedge clk);
            #1;
        end

        // Ten push/pop pairs crossing the pointer wrap
        for (int k = 0; k < 10; k++) push(ord(32'h2000 + 32'(4 * k), 16'(16'h100 + k)), 1'b0);
        @(negedge clk);
        chk("stream_count", 128'(count), 128'(1));
        @(posedge clk);
        #1;
        cyc(2);

        // Load-use hazard on head addu r3,r4,r5; second instance never holds
        bus.out_ready_i = 1'b0;
        bus1.in_valid_i = 1'b1; bus1.in_pc_i = 32'h3000; bus1.in_inst_i = 32'h00851821;
        push(fx(32'h3000, 32'h00851821,
            uf(0, 12'h001, 8'h00, 1, 1, 5'd4, 5'd5, 1, 5'd3, 32'h0, 3'b000, 4'd0, 32'h0, 0)),
            1'b0);
        bus1.in_valid_i = 1'b0;
        ex_lv = 1'b1; ex_lw = 5'd5;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("hold_valid", 128'(bus.out_valid_o), 128'(0));
            chk("nohold_param_valid", 128'(bus1.out_valid_o), 128'(1));
            @(posedge clk);
            #1;
        end
        ex_lw = 5'd0;
        @(negedge clk);
        chk("stall_cnt_2", 128'(stall), 128'(2));
        chk("r0_no_hold", 128'(bus.out_valid_o), 128'(1));
        chk("nohold_param_stall", 128'(stall1), 128'(0));
        @(posedge clk);
        #1 ex_lw = 5'd4;
        @(negedge clk);
        chk("rs_hold_valid", 128'(bus.out_valid_o), 128'(0));
        chk("r0_no_count", 128'(stall), 128'(2));
        @(posedge clk);
        #1 ex_lv = 1'b0;
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        chk("stall_cnt_3", 128'(stall), 128'(3));
        @(posedge clk);
        #1;
        cyc(1);
        chk("scoreboard_drained", 128'(sb_q.size()), 128'(0));

        // Flush with 3 entries and a same-cycle push and pop request
        bus.out_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) push(ord(32'h4000 + 32'(4 * k), 16'(16'h200 + k)), 1'b0);
        flush = 1'b1;
        bus.out_ready_i = 1'b1;
        bus.in_valid_i = 1'b1; bus.in_pc_i = 32'h4100; bus.in_inst_i = 32'h24220300;
        @(negedge clk);
        chk("flush_cycle_valid", 128'(bus.out_valid_o), 128'(0));
        chk("flush_cycle_count", 128'(count), 128'(3));
        sb_q.delete();
        @(posedge clk);
        #1;
        flush = 1'b0;
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        chk_idle("post_flush", 16'd3);
        @(posedge clk);
        #1;
        push(ord(32'h4200, 16'h0300), 1'b0);
        cyc(2);

        // Mid-stream reset
        bus.out_ready_i = 1'b0;
        push(ord(32'h5000, 16'h0400), 1'b0);
        push(ord(32'h5004, 16'h0401), 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        sb_q.delete();
        @(negedge clk);
        chk_idle("mid_reset", 16'd0);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got no finish expected finish before 50000");
        $fatal(1, "watchdog expired");
    end
endmodule
